// File: rtl/fsk_seq_pkg.sv
// Shared types, default sizes and the FWORD helper for the M-FSK frequency-word sequencer.
package fsk_seq_pkg;

  localparam int N_DEF          = 32;
  localparam int SYM_BITS_DEF   = 2;
  localparam int PER_BITS_DEF   = 24;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } fsk_state_e;

  // Modulo-2^N: overflow of the product and the sum wraps silently.
  function automatic logic [N_DEF-1:0] fword_of(input logic [N_DEF-1:0] base,
                                                input logic [N_DEF-1:0] step,
                                                input logic [N_DEF-1:0] sym);
    return base + sym * step;
  endfunction

endpackage

// File: rtl/fsk_sym_fifo.sv
// Synchronous symbol FIFO with full/empty flags and a single-cycle flush.
module fsk_sym_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + AW'(1);
      end
      if (do_pop) rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fsk_fword_seq.sv
// M-FSK FWORD sequencer: buffers symbols, holds base+sym*step for sym_period clocks each.
// Optional FSEQ_SYMCNT_EN adds a 16-bit popped-symbol counter output sym_count.
module fsk_fword_seq
  import fsk_seq_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int SYM_BITS   = SYM_BITS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int PER_BITS   = PER_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        base_fword,
  input  logic [N-1:0]        step_fword,
  input  logic [PER_BITS-1:0] sym_period,
  input  logic [SYM_BITS-1:0] sym_data,
  input  logic                sym_valid,
  output logic                sym_ready,
  input  logic                start,
  input  logic                abort,
  output logic [N-1:0]        FWORD,
  output logic                tx_en,
  output logic                busy,
  output logic [1:0]          state_dbg
`ifdef FSEQ_SYMCNT_EN
  ,
  output logic [15:0]         sym_count
`endif
);

  // Handshake: a symbol transfers on any clk where sym_valid && sym_ready and
  // abort is low; sym_ready is !full from registered state, so a pop in the
  // same cycle never opens room for a push.
  logic                full, empty, pop, push;
  logic [SYM_BITS-1:0] head;

  fsk_state_e          state_q, state_d;
  logic [PER_BITS-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [N-1:0]        base_q, base_d, step_q, step_d, fword_q, fword_d;
  logic                tx_en_q, tx_en_d;
`ifdef FSEQ_SYMCNT_EN
  logic [15:0]         sym_count_q, sym_count_d;
`endif

  assign sym_ready = !full;
  assign push      = sym_valid && !full && !abort;
  assign FWORD     = fword_q;
  assign tx_en     = tx_en_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  fsk_sym_fifo #(.W(SYM_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (push),
    .din   (sym_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    base_d   = base_q;
    step_d   = step_q;
    fword_d  = fword_q;
    tx_en_d  = tx_en_q;
    pop      = 1'b0;
    if (abort) begin
      state_d = IDLE;
      tx_en_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start && !empty) begin
          state_d  = LOAD;
          base_d   = base_fword;
          step_d   = step_fword;
          period_d = (sym_period == '0) ? PER_BITS'(1) : sym_period;
        end
        LOAD: begin
          pop     = 1'b1;
          fword_d = N'(fword_of(N_DEF'(base_q), N_DEF'(step_q), N_DEF'(head)));
          cnt_d   = period_q - PER_BITS'(1);
          tx_en_d = 1'b1;
          state_d = RUN;
        end
        RUN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - PER_BITS'(1);
          end else if (!empty) begin
            // Seamless hand-over: next symbol starts on the very next clk.
            pop     = 1'b1;
            fword_d = N'(fword_of(N_DEF'(base_q), N_DEF'(step_q), N_DEF'(head)));
            cnt_d   = period_q - PER_BITS'(1);
          end else begin
            state_d = IDLE;
            tx_en_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef FSEQ_SYMCNT_EN
  assign sym_count = sym_count_q;

  always_comb begin
    sym_count_d = sym_count_q;
    if (!abort) begin
      if (state_q == IDLE && state_d == LOAD) sym_count_d = '0;
      else if (pop)                           sym_count_d = sym_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sym_count_q <= '0;
    else     sym_count_q <= sym_count_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      base_q   <= '0;
      step_q   <= '0;
      fword_q  <= '0;
      tx_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      base_q   <= base_d;
      step_q   <= step_d;
      fword_q  <= fword_d;
      tx_en_q  <= tx_en_d;
    end
  end

endmodule

// File: tb/tb_fsk_fword_seq.sv
// Bench for fsk_fword_seq: expected FWORD per on-air clock queued at push time, checked while tx_en is high.
module tb_fsk_fword_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] base_fword, step_fword;
  logic [23:0] sym_period;
  logic [1:0]  sym_data;
  logic        sym_valid, sym_ready, start, abort;
  logic [31:0] FWORD;
  logic        tx_en, busy;
  logic [1:0]  state_dbg;
`ifdef FSEQ_SYMCNT_EN
  logic [15:0] sym_count;
`endif

  always #5 clk = ~clk;

  fsk_fword_seq dut (
    .clk        (clk),
    .rst        (rst),
    .base_fword (base_fword),
    .step_fword (step_fword),
    .sym_period (sym_period),
    .sym_data   (sym_data),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .start      (start),
    .abort      (abort),
    .FWORD      (FWORD),
    .tx_en      (tx_en),
    .busy       (busy),
    .state_dbg  (state_dbg)
`ifdef FSEQ_SYMCNT_EN
    ,
    .sym_count  (sym_count)
`endif
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  int          tx_cycles = 0;
  int          mcount = 0;
  bit          mon_en = 1'b0;
  logic [31:0] cur_base, cur_step;
  int          eff_period;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && tx_en) begin
      tx_cycles++;
      if (exp_q.size() == 0) check_eq("unexpected_on_air", 32'(tx_en), 32'd0);
      else                   check_eq("fword", FWORD, exp_q.pop_front());
    end
  end

  task automatic set_cfg(input logic [31:0] b, input logic [31:0] s, input int p);
    @(negedge clk);
    base_fword = b;
    step_fword = s;
    sym_period = 24'(p);
    cur_base   = b;
    cur_step   = s;
    eff_period = (p == 0) ? 1 : p;
  endtask

  task automatic send(input logic [1:0] s);
    logic        acc;
    logic        exp_acc;
    logic [31:0] fw;
    @(negedge clk);
    sym_data  = s;
    sym_valid = 1'b1;
    acc       = sym_ready;
    exp_acc   = (mcount < 8);
    check_eq("push_ready", 32'(acc), 32'(exp_acc));
    if (exp_acc) begin
      mcount++;
      fw = cur_base + {30'd0, s} * cur_step;
      for (int p = 0; p < eff_period; p++) exp_q.push_back(fw);
    end
    @(posedge clk);
    #1 sym_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic exp_busy);
    @(negedge clk);
    tx_cycles = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_busy", 32'(busy), 32'(exp_busy));
    check_eq("start_txen_latency", 32'(tx_en), 32'd0);
    // Latched values must not follow input changes after start.
    base_fword = $urandom;
    step_fword = $urandom;
    sym_period = 24'($urandom_range(0, 9));
  endtask

  task automatic wait_done(input int exp_cycles);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_in_time", 32'(busy), 32'd0);
    check_eq("done_txen", 32'(tx_en), 32'd0);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    check_eq("tx_cycles", 32'(tx_cycles), 32'(exp_cycles));
    exp_q.delete();
    mcount = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; base_fword = '0; step_fword = '0; sym_period = '0;
    sym_data = '0; sym_valid = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_fword", FWORD, 32'd0);
    check_eq("rst_txen", 32'(tx_en), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(sym_ready), 32'd1);
    rst = 1'b0;
    mon_en = 1'b1;

    // Basic three-symbol message
    set_cfg(32'd1000, 32'd10, 4);
    send(2'd0); send(2'd3); send(2'd1);
    pulse_start(1'b1);
    wait_done(12);
    check_eq("idle_hold", FWORD, 32'd1010);
`ifdef FSEQ_SYMCNT_EN
    check_eq("sym_count", 32'(sym_count), 32'd3);
`endif

    // Fill to full; ninth push refused
    set_cfg($urandom, $urandom, 2);
    for (int i = 0; i < 9; i++) send(2'($urandom_range(0, 3)));
    pulse_start(1'b1);
    wait_done(16);

    // Period 0 and 1 both mean one clk per symbol
    for (int p = 0; p < 2; p++) begin
      set_cfg($urandom, $urandom, p);
      send(2'd2); send(2'd1); send(2'd3);
      pulse_start(1'b1);
      wait_done(3);
    end

    // Modulo wrap
    set_cfg(32'hFFFF_FFF0, 32'h20, 2);
    send(2'd1);
    pulse_start(1'b1);
    wait_done(2);
    check_eq("wrap", FWORD, 32'h0000_0010);

    // Push while running extends the message
    set_cfg(32'd500, 32'd7, 6);
    send(2'd1); send(2'd2);
    pulse_start(1'b1);
    send(2'd3);
    wait_done(18);

    // Abort during the second symbol
    set_cfg(32'd1000, 32'd10, 4);
    send(2'd0); send(2'd1); send(2'd2);
    pulse_start(1'b1);
    n = 0;
    while (tx_cycles < 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_txen", 32'(tx_en), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_ready", 32'(sym_ready), 32'd1);
    check_eq("abort_fword_hold", FWORD, 32'd1010);
    exp_q.delete();
    mcount = 0;
    pulse_start(1'b0);
    @(negedge clk);
    check_eq("empty_start_idle", 32'(busy), 32'd0);

    // Synchronous reset mid-run
    set_cfg(32'd77, 32'd3, 5);
    send(2'd1); send(2'd2);
    pulse_start(1'b1);
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_fword", FWORD, 32'd0);
    check_eq("midrst_txen", 32'(tx_en), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_ready", 32'(sym_ready), 32'd1);
    rst = 1'b0;
    exp_q.delete();
    mcount = 0;

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
